gauss_sram_writer: RTL and testbench



---
 rtl/gauss_pkg.sv | 17 +
 rtl/gauss_sample_fifo.sv | 59 +++++
 rtl/gauss_sram_writer.sv | 159 +++++++++++++++
 tb/tb_gauss_sram_writer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared types for the Gaussian-sample SRAM writer: sample format,
// SRAM word width and the write-FSM state encoding.
package gauss_pkg;

    // Q17.15 two's complement Gaussian sample
    typedef logic signed [31:0] sample_t;

    localparam int SRAM_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD
    } wr_state_t;

endpackage

// File: rtl/gauss_sample_fifo.sv
// Single-clock sample FIFO. dout shows the head combinationally;
// full/empty are registered from the next-cycle occupancy.
module gauss_sample_fifo
    import gauss_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    nreset,
    input  logic    push,
    input  sample_t din,
    input  logic    pop,
    output sample_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    sample_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_nxt;
    logic               do_push;
    logic               do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // next occupancy, used to register full/empty
    always_comb begin
        count_nxt = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    // pointers, occupancy and status flags
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == (PTR_W+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gauss_sram_writer.sv
// Buffers Ziggurat Gaussian samples and writes each one to a 16-bit async
// SRAM as two words (low half, then high half).
// Optional: DROP_CNT_EN enables the saturating drop counter; otherwise
// drop_cnt is tied to zero.
module gauss_sram_writer
    import gauss_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WE_CYCLES  = 2,
    parameter int ADDR_W     = 18
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   start,
    input  logic [31:0]            sample_in,
    input  logic                   invalid_in,
    input  logic                   complete_in,
    inout  wire  [SRAM_WORD_W-1:0] SRAM_DATA,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic                   SRAM_nCS,
    output logic                   SRAM_nOE,
    output logic                   SRAM_nWE,
    output logic [ADDR_W-2:0]      stored_cnt,
    output logic                   mem_full,
    output logic [23:0]            drop_cnt,
    output logic                   done
);

    localparam int WE_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    wr_state_t                state;
    wr_state_t                state_nxt;
    sample_t                  hold;
    logic                     half;
    logic [WE_W-1:0]          we_cnt;
    logic                     we_last;
    logic [ADDR_W-1:0]        addr;
    logic                     complete_seen;
    logic                     push_req;
    logic                     push_ok;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    sample_t                  fifo_dout;
    logic                     bus_drive;
    logic [SRAM_WORD_W-1:0]   bus_word;

    // Fullness is the registered flag, so a push into a full FIFO is
    // dropped even when the FSM pops in the same cycle.
    assign push_req = start & ~invalid_in & ~done;
    assign push_ok  = push_req & ~fifo_full & ~mem_full;

    gauss_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push_ok),
        .din    (sample_in),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign we_last = (we_cnt == WE_W'(WE_CYCLES - 1));

    // write FSM state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    // write FSM next state and FIFO pop
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !mem_full) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP:   state_nxt = WRITE;
            WRITE:   if (we_last) state_nxt = HOLD;
            HOLD:    state_nxt = half ? IDLE : SETUP;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM strobes decoded from state so reset releases them immediately
    always_comb begin
        SRAM_nCS  = (state == IDLE);
        SRAM_nOE  = 1'b1;
        SRAM_nWE  = (state != WRITE);
        bus_drive = (state != IDLE);
        bus_word  = half ? hold[31:16] : hold[15:0];
    end

    assign SRAM_DATA = bus_drive ? bus_word : {SRAM_WORD_W{1'bz}};
    assign SRAM_ADDR = addr;

    // Word address 2^ADDR_W-1 is always a high half, so mem_full is only
    // ever raised at the end of a complete sample.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold       <= '0;
            half       <= 1'b0;
            we_cnt     <= '0;
            addr       <= '0;
            stored_cnt <= '0;
            mem_full   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold <= fifo_dout;
                        half <= 1'b0;
                    end
                end
                SETUP: we_cnt <= '0;
                WRITE: we_cnt <= we_cnt + WE_W'(1);
                HOLD: begin
                    if (addr == '1) mem_full <= 1'b1;
                    else            addr     <= addr + ADDR_W'(1);
                    if (half) stored_cnt <= stored_cnt + (ADDR_W-1)'(1);
                    else      half       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // latch upstream completion and raise sticky done once drained
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            complete_seen <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (complete_in) complete_seen <= 1'b1;
            if (complete_seen && fifo_empty && (state == IDLE)) done <= 1'b1;
        end
    end

`ifdef DROP_CNT_EN
    // saturating count of samples that could not be buffered
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            drop_cnt <= '0;
        end else if (push_req && !push_ok && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 24'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_gauss_sram_writer.sv
// Directed bench for gauss_sram_writer: a default-size instance plus a
// 4-bit-address instance for the address-limit scenario.
module tb_gauss_sram_writer;

    logic        clk = 1'b0;
    logic        nreset;

    logic        start_a, invalid_a, complete_a;
    logic [31:0] sample_a;
    wire  [15:0] data_a;
    logic [17:0] addr_a;
    logic        ncs_a, noe_a, nwe_a, full_a, done_a;
    logic [16:0] stored_a;
    logic [23:0] drop_a;

    logic        start_b, invalid_b, complete_b;
    logic [31:0] sample_b;
    wire  [15:0] data_b;
    logic [3:0]  addr_b;
    logic        ncs_b, noe_b, nwe_b, full_b, done_b;
    logic [2:0]  stored_b;
    logic [23:0] drop_b;

    int tests_run = 0;
    int tests_failed = 0;

    // logged word writes (one entry per nWE low pulse)
    int          a_addr[$];
    logic [15:0] a_data[$];
    int          a_len[$];
    int          a_unstable;
    int          b_addr[$];
    logic [15:0] b_data[$];

    pullup (data_a);
    pullup (data_b);

    always #5 clk = ~clk;

    gauss_sram_writer #(
        .FIFO_DEPTH (8),
        .WE_CYCLES  (2),
        .ADDR_W     (18)
    ) dut (
        .clk (clk), .nreset (nreset), .start (start_a), .sample_in (sample_a),
        .invalid_in (invalid_a), .complete_in (complete_a), .SRAM_DATA (data_a),
        .SRAM_ADDR (addr_a), .SRAM_nCS (ncs_a), .SRAM_nOE (noe_a), .SRAM_nWE (nwe_a),
        .stored_cnt (stored_a), .mem_full (full_a), .drop_cnt (drop_a), .done (done_a)
    );

    gauss_sram_writer #(
        .FIFO_DEPTH (8),
        .WE_CYCLES  (2),
        .ADDR_W     (4)
    ) dut_small (
        .clk (clk), .nreset (nreset), .start (start_b), .sample_in (sample_b),
        .invalid_in (invalid_b), .complete_in (complete_b), .SRAM_DATA (data_b),
        .SRAM_ADDR (addr_b), .SRAM_nCS (ncs_b), .SRAM_nOE (noe_b), .SRAM_nWE (nwe_b),
        .stored_cnt (stored_b), .mem_full (full_b), .drop_cnt (drop_b), .done (done_b)
    );

    // word-write monitor for the default instance
    int          a_cur_len = 0;
    int          a_cur_addr;
    logic [15:0] a_cur_data;
    always @(negedge clk) begin
        if (!nreset) begin
            a_addr.delete(); a_data.delete(); a_len.delete();
            a_cur_len = 0; a_unstable = 0;
        end else if (nwe_a == 1'b0) begin
            if (a_cur_len == 0) begin
                a_cur_addr = int'(addr_a);
                a_cur_data = data_a;
            end else if (int'(addr_a) != a_cur_addr || data_a !== a_cur_data) begin
                a_unstable++;
            end
            a_cur_len++;
        end else if (a_cur_len != 0) begin
            a_addr.push_back(a_cur_addr);
            a_data.push_back(a_cur_data);
            a_len.push_back(a_cur_len);
            a_cur_len = 0;
        end
    end

    // word-write monitor for the small instance
    logic        b_in_write = 1'b0;
    int          b_cur_addr;
    logic [15:0] b_cur_data;
    always @(negedge clk) begin
        if (!nreset) begin
            b_addr.delete(); b_data.delete(); b_in_write = 1'b0;
        end else if (nwe_b == 1'b0) begin
            b_in_write = 1'b1;
            b_cur_addr = int'(addr_b);
            b_cur_data = data_b;
        end else if (b_in_write) begin
            b_addr.push_back(b_cur_addr);
            b_data.push_back(b_cur_data);
            b_in_write = 1'b0;
        end
    end

    task automatic idle_inputs();
        start_a = 0; invalid_a = 0; complete_a = 0; sample_a = '0;
        start_b = 0; invalid_b = 0; complete_b = 0; sample_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nreset = 0;
        repeat (2) @(negedge clk);
        nreset = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        nreset = 0;
        #1;
        tests_run++; if (ncs_a !== 1'b1) begin tests_failed++; $display("FAIL reset_ncs got %b want 1", ncs_a); end
        tests_run++; if (noe_a !== 1'b1) begin tests_failed++; $display("FAIL reset_noe got %b want 1", noe_a); end
        tests_run++; if (nwe_a !== 1'b1) begin tests_failed++; $display("FAIL reset_nwe got %b want 1", nwe_a); end
        tests_run++; if (data_a !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_bus got %h want released (FFFF pull)", data_a); end
        tests_run++; if (addr_a !== 18'd0) begin tests_failed++; $display("FAIL reset_addr got %0d want 0", addr_a); end
        tests_run++; if (stored_a !== 17'd0) begin tests_failed++; $display("FAIL reset_stored got %0d want 0", stored_a); end
        tests_run++; if (full_a !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_full got %b want 0", full_a); end
        tests_run++; if (drop_a !== 24'd0) begin tests_failed++; $display("FAIL reset_drop got %0d want 0", drop_a); end
        tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done_a); end
        @(negedge clk);
        nreset = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        do_reset();
        start_a = 1; sample_a = 32'h0001_8000;
        @(negedge clk);
        start_a = 0;
        n = 1;
        while (stored_a != 17'd1 && n < 40) begin @(negedge clk); n++; end
        // accept edge, one IDLE pop cycle, then 2 x (SETUP + 2 WRITE + HOLD)
        tests_run++; if (n != 10) begin tests_failed++; $display("FAIL single_latency got %0d want 10 edges", n); end
        tests_run++; if (a_addr.size() != 2) begin tests_failed++; $display("FAIL single_words got %0d want 2", a_addr.size()); end
        if (a_addr.size() == 2) begin
            tests_run++; if (a_addr[0] != 0 || a_data[0] !== 16'h8000) begin tests_failed++; $display("FAIL single_w0 got @%0d=%h want @0=8000", a_addr[0], a_data[0]); end
            tests_run++; if (a_addr[1] != 1 || a_data[1] !== 16'h0001) begin tests_failed++; $display("FAIL single_w1 got @%0d=%h want @1=0001", a_addr[1], a_data[1]); end
            tests_run++; if (a_len[0] != 2 || a_len[1] != 2) begin tests_failed++; $display("FAIL single_we_len got %0d/%0d want 2/2", a_len[0], a_len[1]); end
        end
        tests_run++; if (a_unstable != 0) begin tests_failed++; $display("FAIL single_stable got %0d changes want 0", a_unstable); end
        tests_run++; if (ncs_a !== 1'b1 || data_a !== 16'hFFFF) begin tests_failed++; $display("FAIL single_release got ncs=%b bus=%h want 1/FFFF", ncs_a, data_a); end
    endtask

    task automatic test_invalid_filter();
        logic [31:0] vals [6];
        int n;
        int idx;
        vals = '{32'hAAAA_0A0A, 32'hBBBB_0B0B, 32'hCCCC_0C0C,
                 32'hDDDD_0D0D, 32'hEEEE_0E0E, 32'hFFFF_0F0F};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            start_a = 1; invalid_a = (i % 2 == 1); sample_a = vals[i];
            @(negedge clk);
        end
        start_a = 0; invalid_a = 0;
        n = 0;
        while (stored_a != 17'd3 && n < 80) begin @(negedge clk); n++; end
        tests_run++; if (a_addr.size() != 6) begin tests_failed++; $display("FAIL invalid_words got %0d want 6", a_addr.size()); end
        if (a_addr.size() == 6) begin
            for (int k = 0; k < 3; k++) begin
                idx = 2 * k;
                tests_run++;
                if (a_addr[2*k] != 2*k || a_data[2*k] !== vals[idx][15:0] ||
                    a_addr[2*k+1] != 2*k+1 || a_data[2*k+1] !== vals[idx][31:16]) begin
                    tests_failed++;
                    $display("FAIL invalid_sample%0d got @%0d=%h @%0d=%h want @%0d=%h @%0d=%h", k,
                             a_addr[2*k], a_data[2*k], a_addr[2*k+1], a_data[2*k+1],
                             2*k, vals[idx][15:0], 2*k+1, vals[idx][31:16]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        int acc [10];
        logic [23:0] want_drop;
        acc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11};
`ifdef DROP_CNT_EN
        want_drop = 24'd10;
`else
        want_drop = 24'd0;
`endif
        do_reset();
        for (int i = 0; i < 20; i++) begin
            start_a = 1; invalid_a = 0;
            sample_a = {16'(16'hC000 + i), 16'(16'h3000 + i)};
            @(negedge clk);
        end
        start_a = 0;
        tests_run++; if (a_addr.size() != 4) begin tests_failed++; $display("FAIL ovf_burst_words got %0d want 4", a_addr.size()); end
        tests_run++; if (stored_a !== 17'd2) begin tests_failed++; $display("FAIL ovf_burst_stored got %0d want 2", stored_a); end
        tests_run++; if (drop_a !== want_drop) begin tests_failed++; $display("FAIL ovf_drop got %0d want %0d", drop_a, want_drop); end
        n = 0;
        while (stored_a != 17'd10 && n < 200) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        tests_run++; if (stored_a !== 17'd10) begin tests_failed++; $display("FAIL ovf_stored got %0d want 10", stored_a); end
        tests_run++; if (a_addr.size() != 20) begin tests_failed++; $display("FAIL ovf_words got %0d want 20", a_addr.size()); end
        if (a_addr.size() == 20) begin
            for (int k = 0; k < 10; k++) begin
                tests_run++;
                if (a_addr[2*k] != 2*k || a_data[2*k] !== 16'(16'h3000 + acc[k]) ||
                    a_data[2*k+1] !== 16'(16'hC000 + acc[k])) begin
                    tests_failed++;
                    $display("FAIL ovf_sample%0d got @%0d=%h hi=%h want @%0d=%h hi=%h", k,
                             a_addr[2*k], a_data[2*k], a_data[2*k+1],
                             2*k, 16'(16'h3000 + acc[k]), 16'(16'hC000 + acc[k]));
                end
            end
        end
        tests_run++; if (drop_a !== want_drop) begin tests_failed++; $display("FAIL ovf_drop_after got %0d want %0d", drop_a, want_drop); end
        tests_run++; if (a_unstable != 0) begin tests_failed++; $display("FAIL ovf_stable got %0d changes want 0", a_unstable); end
    endtask

    task automatic test_done();
        int n;
        int early;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            start_a = 1; sample_a = 32'h0700_0000 + i;
            @(negedge clk);
        end
        start_a = 0; complete_a = 1;
        @(negedge clk);
        complete_a = 0;
        n = 0; early = 0;
        while (stored_a != 17'd3 && n < 60) begin
            if (done_a) early++;
            @(negedge clk); n++;
        end
        tests_run++; if (early != 0) begin tests_failed++; $display("FAIL done_early got %0d cycles high want 0", early); end
        tests_run++; if (stored_a !== 17'd3) begin tests_failed++; $display("FAIL done_stored got %0d want 3", stored_a); end
        tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("FAIL done_at_hold_exit got %b want 0", done_a); end
        @(negedge clk);
        tests_run++; if (done_a !== 1'b1) begin tests_failed++; $display("FAIL done_set got %b want 1", done_a); end
        // once done, further samples are ignored
        for (int i = 0; i < 3; i++) begin
            start_a = 1; sample_a = 32'h1234_5678;
            @(negedge clk);
        end
        start_a = 0;
        repeat (20) @(negedge clk);
        tests_run++; if (done_a !== 1'b1) begin tests_failed++; $display("FAIL done_sticky got %b want 1", done_a); end
        tests_run++; if (a_addr.size() != 6 || stored_a !== 17'd3) begin tests_failed++; $display("FAIL done_blocks got words=%0d stored=%0d want 6/3", a_addr.size(), stored_a); end
    endtask

    task automatic test_reset_mid_write();
        int n;
        do_reset();
        start_a = 1; sample_a = 32'h1111_2222;
        @(negedge clk);
        sample_a = 32'h3333_4444;
        @(negedge clk);
        start_a = 0;
        n = 0;
        while (!(nwe_a == 1'b0 && addr_a == 18'd3) && n < 60) begin @(negedge clk); n++; end
        tests_run++; if (n >= 60) begin tests_failed++; $display("FAIL midrst_reach got timeout want WRITE at word 3"); end
        tests_run++; if (stored_a !== 17'd1 || data_a !== 16'h3333) begin tests_failed++; $display("FAIL midrst_pre got stored=%0d bus=%h want 1/3333", stored_a, data_a); end
        nreset = 0;
        #1;
        tests_run++; if (nwe_a !== 1'b1 || ncs_a !== 1'b1) begin tests_failed++; $display("FAIL midrst_strobes got nwe=%b ncs=%b want 1/1", nwe_a, ncs_a); end
        tests_run++; if (data_a !== 16'hFFFF) begin tests_failed++; $display("FAIL midrst_bus got %h want released (FFFF pull)", data_a); end
        tests_run++; if (addr_a !== 18'd0 || stored_a !== 17'd0) begin tests_failed++; $display("FAIL midrst_regs got addr=%0d stored=%0d want 0/0", addr_a, stored_a); end
        @(negedge clk);
        nreset = 1;
        @(negedge clk);
    endtask

    task automatic test_addr_limit();
        logic [23:0] want_drop;
`ifdef DROP_CNT_EN
        want_drop = 24'd2;
`else
        want_drop = 24'd0;
`endif
        do_reset();
        for (int k = 0; k < 10; k++) begin
            start_b = 1; sample_b = {16'(16'h5000 + k), 16'(16'h6000 + k)};
            @(negedge clk);
            start_b = 0;
            repeat (11) @(negedge clk);
            if (k == 6) begin
                tests_run++; if (full_b !== 1'b0 || b_addr.size() != 14) begin tests_failed++; $display("FAIL lim_before got full=%b words=%0d want 0/14", full_b, b_addr.size()); end
            end
        end
        repeat (10) @(negedge clk);
        tests_run++; if (full_b !== 1'b1) begin tests_failed++; $display("FAIL lim_mem_full got %b want 1", full_b); end
        tests_run++; if (addr_b !== 4'hF) begin tests_failed++; $display("FAIL lim_addr got %h want F (no wrap)", addr_b); end
        tests_run++; if (b_addr.size() != 16) begin tests_failed++; $display("FAIL lim_words got %0d want 16", b_addr.size()); end
        if (b_addr.size() == 16) begin
            tests_run++; if (b_addr[14] != 14 || b_data[14] !== 16'h6007 || b_addr[15] != 15 || b_data[15] !== 16'h5007) begin
                tests_failed++; $display("FAIL lim_last got @%0d=%h @%0d=%h want @14=6007 @15=5007", b_addr[14], b_data[14], b_addr[15], b_data[15]);
            end
        end
        tests_run++; if (drop_b !== want_drop) begin tests_failed++; $display("FAIL lim_drop got %0d want %0d", drop_b, want_drop); end
        tests_run++; if (ncs_b !== 1'b1 || data_b !== 16'hFFFF) begin tests_failed++; $display("FAIL lim_idle got ncs=%b bus=%h want 1/FFFF", ncs_b, data_b); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        nreset = 1;
        @(negedge clk);
        test_reset();
        test_single();
        test_invalid_filter();
        test_overflow();
        test_done();
        test_reset_mid_write();
        test_addr_limit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
